// File: rtl/bdi_b8_line_compressor.sv
// bdi_b8_line_compressor: base-8 BDI encoder for 256-bit lines, 2-stage valid/ready pipeline with stats
module bdi_b8_line_compressor #(
   parameter int LINE_W = 256,
   parameter int COMP_W = 260,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LINE_W-1:0] in_line,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [COMP_W-1:0] out_comp,
   output logic [3:0]        out_con,
   output logic [CNT_W-1:0]  cnt_lines,
   output logic [CNT_W-1:0]  cnt_compressed
);
   logic              s1_valid_q, s2_valid_q, s1_adv;
   logic [LINE_W-1:0] line_q;
   logic [3:0]        ge_d, ge_q;
   logic [3:0][63:0]  mag_d, mag_q;
   logic              all_zero_d, all_zero_q, all_equal_d, all_equal_q;
   logic              f8, f16, f32;
   logic [3:0]        con_d;
   logic [COMP_W-1:0] pack_d, comp_d, comp_q;
   logic [CNT_W-1:0]  cnt_lines_q, cnt_comp_q;

   // s1 may move into s2 whenever s2 is empty or being drained this cycle
   assign s1_adv    = !s2_valid_q || out_ready;
   assign in_ready  = !s1_valid_q || s1_adv;
   assign all_zero_d = ~|in_line;

   // per-word sign and magnitude of the difference from word 0
   always_comb begin
      all_equal_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ge_d[i]     = in_line[64*i +: 64] >= in_line[63:0];
         mag_d[i]    = ge_d[i] ? in_line[64*i +: 64] - in_line[63:0] : in_line[63:0] - in_line[64*i +: 64];
         all_equal_d = all_equal_d && (in_line[64*i +: 64] == in_line[63:0]);
      end
   end

   // pick the narrowest delta width and pack the compressed word
   always_comb begin
      f8  = 1'b1;
      f16 = 1'b1;
      f32 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         f8  = f8  && (mag_q[i][63:8]  == '0);
         f16 = f16 && (mag_q[i][63:16] == '0);
         f32 = f32 && (mag_q[i][63:32] == '0);
      end
      con_d = all_zero_q ? 4'd0 : all_equal_q ? 4'd1 : f8 ? 4'd2 : f16 ? 4'd3 : f32 ? 4'd4 : 4'd15;
      pack_d = {{(COMP_W-72){1'b0}}, line_q[63:0], ge_q, con_d};
      for (int i = 0; i < 4; i++) begin
         if (con_d == 4'd2) pack_d[72+8*i +: 8] = mag_q[i][7:0];
         if (con_d == 4'd3) pack_d[72+16*i +: 16] = mag_q[i][15:0];
         if (con_d == 4'd4) pack_d[72+32*i +: 32] = mag_q[i][31:0];
      end
      comp_d = con_d == 4'd0  ? '0 :
               con_d == 4'd1  ? {{(COMP_W-68){1'b0}}, line_q[63:0], 4'd1} :
               con_d == 4'd15 ? {line_q, 4'hF} : pack_d;
   end

   // stage 1: capture the line and its difference terms
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         line_q      <= '0;
         ge_q        <= '0;
         mag_q       <= '0;
         all_zero_q  <= 1'b0;
         all_equal_q <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            line_q      <= in_line;
            ge_q        <= ge_d;
            mag_q       <= mag_d;
            all_zero_q  <= all_zero_d;
            all_equal_q <= all_equal_d;
         end
      end
   end

   // stage 2: output register, held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         comp_q     <= '0;
      end else if (s1_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) comp_q <= comp_d;
      end
   end

   // statistics, counted on each output transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_lines_q <= '0;
         cnt_comp_q  <= '0;
      end else if (s2_valid_q && out_ready) begin
         cnt_lines_q <= cnt_lines_q + CNT_W'(1);
         if (comp_q[3:0] != 4'd15) cnt_comp_q <= cnt_comp_q + CNT_W'(1);
      end
   end

   assign out_valid      = s2_valid_q;
   assign out_comp       = comp_q;
   assign out_con        = comp_q[3:0];
   assign cnt_lines      = cnt_lines_q;
   assign cnt_compressed = cnt_comp_q;
endmodule
